riscv_trace_serializer: RTL and testbench
=========================================

RISCV_TRACE_SERIALIZER -- requirements
Module: riscv_trace_serializer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter DEPTH SHALL default to 8 and set the FIFO entries; it must be a power of two and at least 4.
REQ-003 Parameter DROP_W SHALL default to 16 and set the drop counter width.
REQ-004 clk_i  input  1  rising-edge clock.
REQ-005 rst_i  input  1  asynchronous active-high reset.
REQ-006 enable_i  input  1  capture enable; when low, no retire event is accepted.
REQ-007 clr_i  input  1  synchronous clear of the FIFO, the counters and the sticky overflow flag.
REQ-008 ret0_valid_i / ret0_pc_i / ret0_inst_i  input  1/32/32  retire lane 0, the older instruction.
REQ-009 ret1_valid_i / ret1_pc_i / ret1_inst_i  input  1/32/32  retire lane 1, the younger instruction.
REQ-010 trace_valid_o / trace_pc_o / trace_inst_o  output  1/32/32  serialized stream, driving the disassembly debug monitor's valid/pc/inst.
REQ-011 trace_ready_i  input  1  consumer accepts the head entry.
REQ-012 level_o  output  log2(DEPTH)+1  current occupancy.
REQ-013 overflow_o  output  1  sticky flag meaning at least one retire event was dropped.
REQ-014 drop_count_o  output  DROP_W  saturating count of dropped instructions.
REQ-015 retire_count_o  output  32  wrapping count of accepted instructions.

Function
REQ-016 Push count N per cycle SHALL be ret0_valid_i+ret1_valid_i when enable_i=1, else 0.
REQ-017 Both lanes valid SHALL write lane 0 at wr_ptr and lane 1 at wr_ptr+1 (mod DEPTH); lane 1 alone SHALL write at wr_ptr.
REQ-018 The space check SHALL use pre-pop occupancy (conservative): the event is accepted only if DEPTH-level >= N.
REQ-019 A concurrent pop SHALL NOT create space for a push in the same cycle.
REQ-020 A rejected event SHALL drop all of its N instructions; partial acceptance is not allowed.
REQ-021 A drop SHALL set overflow_o and add N to drop_count_o, saturating at all-ones.
REQ-022 Accepted instructions SHALL add N to retire_count_o, wrapping mod 2^32.
REQ-023 The output SHALL be show-ahead: trace_valid_o=(level!=0), and trace_pc_o/trace_inst_o present the head entry.
REQ-024 When trace_valid_o=0, trace_pc_o and trace_inst_o SHALL be 0.
REQ-025 A pop SHALL occur when trace_valid_o&&trace_ready_i, advancing rd_ptr by 1.
REQ-026 An entry written in cycle C SHALL be visible at the output in cycle C+1 at the earliest (one-cycle latency, no bypass).
REQ-027 Occupancy SHALL update as level' = level + accepted N - pop.
REQ-028 Pointers SHALL wrap mod DEPTH.
REQ-029 trace_ready_i while empty SHALL have no effect.
REQ-030 clr_i SHALL take priority over push, pop and drop in the same cycle: pointers, level, both counters and overflow_o go to 0, and that cycle's retire event is discarded and not counted.
REQ-031 The FIFO storage SHALL have no reset; only pointers, level, counters and flags are reset.

Reset
REQ-032 rst_i asserted SHALL immediately force trace_valid_o=0, trace_pc_o=0, trace_inst_o=0, level_o=0, overflow_o=0, drop_count_o=0 and retire_count_o=0.
REQ-033 Assertion of rst_i mid-stream SHALL abandon all buffered entries.
REQ-034 The first push SHALL be accepted on the first clock edge after rst_i deasserts.

Structure
REQ-035 The trace entry width (64: pc,inst) SHALL be defined in riscv_def.v as `TRACE_ENTRY_W.
REQ-036 DEPTH-derived widths SHALL be localparams.
REQ-037 Storage SHALL be one sub-module, riscv_trace_ram (two write ports, one asynchronous read port, DEPTH x `TRACE_ENTRY_W).
REQ-038 Pointer, counter and flag logic SHALL stay in the top module.

Verification
REQ-039 Dual retire: after reset, pc0=0x100/inst0=0x00000013 and pc1=0x104/inst1=0x00A00093 in one cycle, ready=1 -> trace pc 0x100 then 0x104 on consecutive cycles, retire_count_o=2.
REQ-040 Lane-1-only: ret1 pc=0x200 -> single entry pc 0x200, level_o goes 1 then 0.
REQ-041 Overflow: DEPTH=8, ready=0, 3 dual pushes, then 1 single push (level=7), then a dual push -> the dual push is dropped, level_o stays 7, drop_count_o=2, overflow_o=1.
REQ-042 Full with pop: level=7, dual push with ready=1 -> dropped despite the pop, level_o=6.
REQ-043 Clear collision: clr_i coincident with a dual push and pop at level 4 -> level_o=0, counters 0, trace_valid_o=0 the next cycle.
REQ-044 Saturation and wrap: DROP_W=4, force 20 drops -> drop_count_o=15; preload retire_count near 0xFFFFFFFF and push 2 -> wraps to 0x00000000 or 0x00000001 per the start value.

Source files
------------

// File: rtl/riscv_trace_serializer_pkg.sv
// +--------------------------------------------------------------------------+
// | riscv_trace_serializer_pkg                                               |
// | Trace entry type and helpers shared by the serializer and its storage.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`ifndef TRACE_ENTRY_W
`include "riscv_def.v"
`endif

package riscv_trace_serializer_pkg;

   localparam int c_TRACE_ENTRY_W = `TRACE_ENTRY_W;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } trace_entry_t;

   function automatic trace_entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst);
      trace_entry_t e;
      e.pc   = pc;
      e.inst = inst;
      return e;
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_def.v
// +--------------------------------------------------------------------------+
// | riscv_def                                                                |
// | Shared RISC-V trace definitions: width of one {pc, inst} trace entry.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`ifndef RISCV_DEF_V
`define RISCV_DEF_V
`define TRACE_ENTRY_W 64
`endif
`default_nettype wire

// File: rtl/riscv_trace_ram.sv
// +--------------------------------------------------------------------------+
// | riscv_trace_ram                                                          |
// | DEPTH x trace-entry storage, two write ports, asynchronous read, no reset|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`ifndef TRACE_ENTRY_W
`include "riscv_def.v"
`endif

module riscv_trace_ram
   import riscv_trace_serializer_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          we0_i,
   input  logic [AW-1:0] waddr0_i,
   input  trace_entry_t  wdata0_i,
   input  logic          we1_i,
   input  logic [AW-1:0] waddr1_i,
   input  trace_entry_t  wdata1_i,
   input  logic [AW-1:0] raddr_i,
   output trace_entry_t  rdata_o
);

   logic [c_TRACE_ENTRY_W-1:0] r_mem [DEPTH];

   // The two write addresses are always distinct (wr_ptr and wr_ptr+1).
   always_ff @(posedge clk_i) begin
      if (we0_i) r_mem[waddr0_i] <= wdata0_i;
      if (we1_i) r_mem[waddr1_i] <= wdata1_i;
   end

   assign rdata_o = r_mem[raddr_i];

endmodule
`default_nettype wire

// File: rtl/riscv_trace_serializer.sv
// +--------------------------------------------------------------------------+
// | riscv_trace_serializer                                                   |
// | Serializes a dual-lane retire stream into a single show-ahead trace FIFO.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none
`ifndef TRACE_ENTRY_W
`include "riscv_def.v"
`endif

module riscv_trace_serializer
   import riscv_trace_serializer_pkg::*;
#(
   parameter int DEPTH  = 8,
   parameter int DROP_W = 16
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      enable_i,
   input  logic                      clr_i,
   input  logic                      ret0_valid_i,
   input  logic [31:0]               ret0_pc_i,
   input  logic [31:0]               ret0_inst_i,
   input  logic                      ret1_valid_i,
   input  logic [31:0]               ret1_pc_i,
   input  logic [31:0]               ret1_inst_i,
   output logic                      trace_valid_o,
   output logic [31:0]               trace_pc_o,
   output logic [31:0]               trace_inst_o,
   input  logic                      trace_ready_i,
   output logic [$clog2(DEPTH):0]    level_o,
   output logic                      overflow_o,
   output logic [DROP_W-1:0]         drop_count_o,
   output logic [31:0]               retire_count_o
);

   localparam int c_AW = $clog2(DEPTH);
   localparam int c_LW = c_AW + 1;

   logic [c_AW-1:0]   r_wr_ptr;
   logic [c_AW-1:0]   r_rd_ptr;
   logic [c_LW-1:0]   r_level;
   logic              r_overflow;
   logic [DROP_W-1:0] r_drop_count;
   logic [31:0]       r_retire_count;

   logic [1:0]        w_n;
   logic [1:0]        w_acc_n;
   logic [c_LW-1:0]   w_free;
   logic              w_accept;
   logic              w_drop;
   logic              w_pop;
   logic [DROP_W:0]   w_drop_sum;
   trace_entry_t      w_wdata0;
   trace_entry_t      w_rdata;

   assign w_n = enable_i ? ({1'b0, ret0_valid_i} + {1'b0, ret1_valid_i}) : 2'd0;

   // Space is judged on pre-pop occupancy, so a same-cycle pop never helps.
   assign w_free   = c_LW'(DEPTH) - r_level;
   assign w_accept = (w_n != 2'd0) && (w_free >= {{(c_LW-2){1'b0}}, w_n});
   assign w_drop   = (w_n != 2'd0) && !w_accept;
   assign w_acc_n  = w_accept ? w_n : 2'd0;
   assign w_pop    = (r_level != '0) && trace_ready_i;

   assign w_drop_sum = {1'b0, r_drop_count} + (DROP_W+1)'(w_n);

   // A lone lane-1 instruction goes through write port 0 at wr_ptr.
   assign w_wdata0 = ret0_valid_i ? make_entry(ret0_pc_i, ret0_inst_i)
                                  : make_entry(ret1_pc_i, ret1_inst_i);

   riscv_trace_ram #(
      .DEPTH (DEPTH),
      .AW    (c_AW)
   ) u_ram (
      .clk_i    (clk_i),
      .we0_i    (w_accept && !clr_i),
      .waddr0_i (r_wr_ptr),
      .wdata0_i (w_wdata0),
      .we1_i    (w_accept && !clr_i && (w_n == 2'd2)),
      .waddr1_i (r_wr_ptr + c_AW'(1)),
      .wdata1_i (make_entry(ret1_pc_i, ret1_inst_i)),
      .raddr_i  (r_rd_ptr),
      .rdata_o  (w_rdata)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_overflow     <= 1'b0;
         r_drop_count   <= '0;
         r_retire_count <= '0;
      end else if (clr_i) begin
         r_wr_ptr       <= '0;
         r_rd_ptr       <= '0;
         r_level        <= '0;
         r_overflow     <= 1'b0;
         r_drop_count   <= '0;
         r_retire_count <= '0;
      end else begin
         r_wr_ptr       <= r_wr_ptr + c_AW'(w_acc_n);
         r_rd_ptr       <= r_rd_ptr + c_AW'(w_pop);
         r_level        <= r_level + c_LW'(w_acc_n) - c_LW'(w_pop);
         r_retire_count <= r_retire_count + 32'(w_acc_n);
         if (w_drop) begin
            r_overflow   <= 1'b1;
            r_drop_count <= w_drop_sum[DROP_W] ? {DROP_W{1'b1}} : w_drop_sum[DROP_W-1:0];
         end
      end
   end

   assign trace_valid_o  = (r_level != '0);
   assign trace_pc_o     = trace_valid_o ? w_rdata.pc   : 32'd0;
   assign trace_inst_o   = trace_valid_o ? w_rdata.inst : 32'd0;
   assign level_o        = r_level;
   assign overflow_o     = r_overflow;
   assign drop_count_o   = r_drop_count;
   assign retire_count_o = r_retire_count;

endmodule
`default_nettype wire

// File: tb/tb_riscv_trace_serializer.sv
// +--------------------------------------------------------------------------+
// | tb_riscv_trace_serializer                                                |
// | Directed self-checking bench for the dual-lane retire trace serializer.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_riscv_trace_serializer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        enable_i = 1'b1;
   logic        clr_i = 1'b0;
   logic        ret0_valid_i = 1'b0;
   logic [31:0] ret0_pc_i = '0;
   logic [31:0] ret0_inst_i = '0;
   logic        ret1_valid_i = 1'b0;
   logic [31:0] ret1_pc_i = '0;
   logic [31:0] ret1_inst_i = '0;
   logic        trace_ready_i = 1'b0;

   logic        a_valid, b_valid;
   logic [31:0] a_pc, a_inst, b_pc, b_inst;
   logic [3:0]  a_level, b_level;
   logic        a_ovf, b_ovf;
   logic [15:0] a_drop;
   logic [3:0]  b_drop;
   logic [31:0] a_ret, b_ret;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   riscv_trace_serializer dut_a (
      .clk_i (clk), .rst_i (rst), .enable_i (enable_i), .clr_i (clr_i),
      .ret0_valid_i (ret0_valid_i), .ret0_pc_i (ret0_pc_i), .ret0_inst_i (ret0_inst_i),
      .ret1_valid_i (ret1_valid_i), .ret1_pc_i (ret1_pc_i), .ret1_inst_i (ret1_inst_i),
      .trace_valid_o (a_valid), .trace_pc_o (a_pc), .trace_inst_o (a_inst),
      .trace_ready_i (trace_ready_i), .level_o (a_level), .overflow_o (a_ovf),
      .drop_count_o (a_drop), .retire_count_o (a_ret)
   );

   riscv_trace_serializer #(.DEPTH (8), .DROP_W (4)) dut_b (
      .clk_i (clk), .rst_i (rst), .enable_i (enable_i), .clr_i (clr_i),
      .ret0_valid_i (ret0_valid_i), .ret0_pc_i (ret0_pc_i), .ret0_inst_i (ret0_inst_i),
      .ret1_valid_i (ret1_valid_i), .ret1_pc_i (ret1_pc_i), .ret1_inst_i (ret1_inst_i),
      .trace_valid_o (b_valid), .trace_pc_o (b_pc), .trace_inst_o (b_inst),
      .trace_ready_i (trace_ready_i), .level_o (b_level), .overflow_o (b_ovf),
      .drop_count_o (b_drop), .retire_count_o (b_ret)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push(input logic v0, input logic [31:0] pc0, input logic [31:0] in0,
                       input logic v1, input logic [31:0] pc1, input logic [31:0] in1);
      ret0_valid_i = v0; ret0_pc_i = pc0; ret0_inst_i = in0;
      ret1_valid_i = v1; ret1_pc_i = pc1; ret1_inst_i = in1;
   endtask

   task automatic idle();
      ret0_valid_i = 1'b0;
      ret1_valid_i = 1'b0;
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      chk("rst_valid", 64'(a_valid), 64'd0);
      chk("rst_pc", 64'(a_pc), 64'd0);
      chk("rst_level", 64'(a_level), 64'd0);
      chk("rst_ovf_drop_ret", {31'd0, a_ovf, a_drop, 16'd0}, 64'd0);
      chk("rst_ret", 64'(a_ret), 64'd0);
      rst = 1'b0;

      // Dual retire on the first edge after reset
      trace_ready_i = 1'b1;
      push(1'b1, 32'h100, 32'h0000_0013, 1'b1, 32'h104, 32'h00A0_0093);
      step();
      idle();
      chk("dual_pc0", 64'(a_pc), 64'h100);
      chk("dual_inst0", 64'(a_inst), 64'h0000_0013);
      chk("dual_level", 64'(a_level), 64'd2);
      chk("dual_retire", 64'(a_ret), 64'd2);
      step();
      chk("dual_pc1", 64'(a_pc), 64'h104);
      chk("dual_inst1", 64'(a_inst), 64'h00A0_0093);
      step();
      chk("empty_valid", 64'(a_valid), 64'd0);
      chk("empty_pc_inst", {a_pc, a_inst}, 64'd0);

      // Lane 1 only
      trace_ready_i = 1'b0;
      push(1'b0, 32'h0, 32'h0, 1'b1, 32'h200, 32'h1234_5678);
      step();
      idle();
      chk("l1_pc", 64'(a_pc), 64'h200);
      chk("l1_inst", 64'(a_inst), 64'h1234_5678);
      chk("l1_level1", 64'(a_level), 64'd1);
      trace_ready_i = 1'b1;
      step();
      chk("l1_level0", 64'(a_level), 64'd0);
      step();
      chk("ready_empty_level", 64'(a_level), 64'd0);

      // Fill to 7, then a dual push is dropped whole
      trace_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         push(1'b1, 32'h300 + 32'(8*k), 32'hA0 + 32'(k), 1'b1, 32'h304 + 32'(8*k), 32'hB0 + 32'(k));
         step();
      end
      push(1'b1, 32'h318, 32'hC0, 1'b0, 32'h0, 32'h0);
      step();
      chk("fill_level7", 64'(a_level), 64'd7);
      push(1'b1, 32'h400, 32'h1, 1'b1, 32'h404, 32'h2);
      step();
      chk("ovf_level", 64'(a_level), 64'd7);
      chk("ovf_drop", 64'(a_drop), 64'd2);
      chk("ovf_flag", 64'(a_ovf), 64'd1);
      chk("ovf_retire", 64'(a_ret), 64'd10);

      // Full with concurrent pop: still dropped
      trace_ready_i = 1'b1;
      step();
      idle();
      chk("fullpop_level", 64'(a_level), 64'd6);
      chk("fullpop_drop", 64'(a_drop), 64'd4);
      chk("fullpop_head", 64'(a_pc), 64'h304);
      chk("fullpop_inst", 64'(a_inst), 64'hB0);

      // Drain to 4, then clear collides with push and pop
      step();
      step();
      chk("pre_clr_level", 64'(a_level), 64'd4);
      chk("pre_clr_head", 64'(a_pc), 64'h30C);
      clr_i = 1'b1;
      push(1'b1, 32'h500, 32'h5, 1'b1, 32'h504, 32'h6);
      step();
      clr_i = 1'b0;
      idle();
      chk("clr_level", 64'(a_level), 64'd0);
      chk("clr_counters", {a_ret, a_drop, 15'd0, a_ovf}, 64'd0);
      chk("clr_valid", 64'(a_valid), 64'd0);

      // Disabled capture neither pushes nor drops
      enable_i = 1'b0;
      push(1'b1, 32'h600, 32'h7, 1'b1, 32'h604, 32'h8);
      step();
      enable_i = 1'b1;
      idle();
      chk("dis_level", 64'(a_level), 64'd0);
      chk("dis_drop_ret", {a_ret, a_drop, 16'd0}, 64'd0);

      // Drop-counter saturation on the narrow instance
      trace_ready_i = 1'b0;
      for (int k = 0; k < 14; k++) begin
         push(1'b1, 32'h700 + 32'(8*k), 32'h0, 1'b1, 32'h704 + 32'(8*k), 32'h0);
         step();
      end
      idle();
      chk("sat_level", 64'(a_level), 64'd8);
      chk("sat_drop_a", 64'(a_drop), 64'd20);
      chk("sat_drop_b", 64'(b_drop), 64'd15);
      chk("sat_ovf_b", 64'(b_ovf), 64'd1);
      chk("full_head", 64'(b_pc), 64'h700);

      // Retire counter wrap from a preloaded value
      clr_i = 1'b1;
      step();
      clr_i = 1'b0;
      force dut_b.r_retire_count = 32'hFFFF_FFFE;
      #1;
      release dut_b.r_retire_count;
      push(1'b1, 32'h800, 32'h9, 1'b1, 32'h804, 32'hA);
      step();
      idle();
      chk("wrap_ret_b", 64'(b_ret), 64'h0);
      chk("wrap_ret_a", 64'(a_ret), 64'd2);
      chk("wrap_level_b", 64'(b_level), 64'd2);

      // Mid-stream asynchronous reset abandons buffered entries
      #2;
      rst = 1'b1;
      #1;
      chk("arst_level", 64'(a_level), 64'd0);
      chk("arst_out", {31'd0, a_valid, a_pc}, 64'd0);
      chk("arst_ret", 64'(a_ret), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      push(1'b1, 32'h900, 32'hB, 1'b0, 32'h0, 32'h0);
      step();
      idle();
      chk("post_rst_pc", 64'(a_pc), 64'h900);
      chk("post_rst_level", 64'(a_level), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
